counter_6bit: RTL and testbench

COUNTER_6BIT -- requirements
Module: counter_6bit

---
 rtl/counter_6bit.sv | 52 +++++
 tb/tb_counter_6bit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/counter_6bit.sv
// counter_6bit: phase counter driving a mirrored quarter-sine LUT address, registered magnitude.
// Define COUNTER_6BIT_SIGN_EN to add the registered sign output (half-period flag).
module counter_6bit #(
  parameter logic [7:0] PEAK_VAL = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [5:0] load_val,
  output logic [5:0] par_out,
  output logic       mirror,
  output logic [5:0] rom_addr,
  input  logic [5:0] rom_data,
  output logic [7:0] magnitude
`ifdef COUNTER_6BIT_SIGN_EN
  ,
  output logic       sign
`endif
);
  logic [5:0] r_par_out;
  logic       r_mirror;
  logic [7:0] r_magnitude;
  logic       w_fold;
  logic       w_wrap;
  assign w_fold    = (r_par_out == 6'd0) && r_mirror;
  assign w_wrap    = !load && en && (r_par_out == 6'd63);
  assign rom_addr  = r_mirror ? 6'd0 - r_par_out : r_par_out;
  assign par_out   = r_par_out;
  assign mirror    = r_mirror;
  assign magnitude = r_magnitude;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_out   <= 6'd0;
      r_mirror    <= 1'b0;
      r_magnitude <= 8'd0;
    end else begin
      if (load) r_par_out <= load_val;
      else if (en) r_par_out <= r_par_out + 6'd1;
      if (w_wrap) r_mirror <= ~r_mirror;
      if (load || en) r_magnitude <= w_fold ? PEAK_VAL : {2'b00, rom_data};
    end
  end
`ifdef COUNTER_6BIT_SIGN_EN
  logic r_sign;
  assign sign = r_sign;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sign <= 1'b0;
    else if (w_wrap && r_mirror) r_sign <= ~r_sign;
  end
`endif
endmodule

// File: tb/tb_counter_6bit.sv
// tb_counter_6bit: directed self-checking bench for counter_6bit.
module tb_counter_6bit;
  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [5:0] load_val;
  logic [5:0] par_out;
  logic       mirror;
  logic [5:0] rom_addr;
  logic [5:0] rom_data;
  logic [7:0] magnitude;
`ifdef COUNTER_6BIT_SIGN_EN
  logic       sign;
`endif
  int checks = 0;
  int errors = 0;

  counter_6bit dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .par_out(par_out), .mirror(mirror), .rom_addr(rom_addr),
    .rom_data(rom_data), .magnitude(magnitude)
`ifdef COUNTER_6BIT_SIGN_EN
    , .sign(sign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 6'd0; rom_data = 6'd0;
    step(1);
    chk("rst_par", 8'(par_out), 8'd0);
    chk("rst_mirror", 8'(mirror), 8'd0);
    chk("rst_mag", magnitude, 8'd0);
    chk("rst_addr", 8'(rom_addr), 8'd0);
    rst = 1'b0;
    step(1);
    // data path: load 5, then one enabled edge samples rom_data
    load = 1'b1; load_val = 6'd5;
    step(1);
    load = 1'b0;
    chk("load5_par", 8'(par_out), 8'd5);
    chk("load5_addr", 8'(rom_addr), 8'd5);
    rom_data = 6'h2A; en = 1'b1;
    step(1);
    chk("mag_2a", magnitude, 8'h2A);
    chk("mag_par", 8'(par_out), 8'd6);
    en = 1'b0; rom_data = 6'h11;
    step(3);
    chk("hold_par", 8'(par_out), 8'd6);
    chk("hold_mag", magnitude, 8'h2A);
    chk("hold_mirror", 8'(mirror), 8'd0);
    chk("hold_addr", 8'(rom_addr), 8'd6);
    // full direct quarter from reset
    rst = 1'b1; #1;
    rst = 1'b0; rom_data = 6'd0; en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("seq_par", 8'(par_out), 8'(i));
      chk("seq_addr", 8'(rom_addr), 8'(i));
      chk("seq_mirror", 8'(mirror), 8'd0);
      step(1);
    end
    chk("wrap_par", 8'(par_out), 8'd0);
    chk("wrap_mirror", 8'(mirror), 8'd1);
    chk("wrap_addr", 8'(rom_addr), 8'd0);
    chk("wrap_mag", magnitude, 8'd0);
    // fold point substitutes PEAK_VAL regardless of rom_data
    rom_data = 6'h07;
    step(1);
    chk("fold_mag", magnitude, 8'd64);
    chk("m1_par", 8'(par_out), 8'd1);
    chk("m1_addr", 8'(rom_addr), 8'd63);
    step(1);
    chk("m2_mag", magnitude, 8'h07);
    chk("m2_addr", 8'(rom_addr), 8'd62);
    en = 1'b0; load = 1'b1; load_val = 6'd63;
    step(1);
    chk("m63_par", 8'(par_out), 8'd63);
    chk("m63_mirror", 8'(mirror), 8'd1);
    chk("m63_addr", 8'(rom_addr), 8'd1);
    load_val = 6'd37;
    step(1);
    load = 1'b0;
    chk("m37_par", 8'(par_out), 8'd37);
    chk("m37_mirror", 8'(mirror), 8'd1);
    chk("m37_mag", magnitude, 8'h07);
    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk("arst_par", 8'(par_out), 8'd0);
    chk("arst_mirror", 8'(mirror), 8'd0);
    chk("arst_mag", magnitude, 8'd0);
    rst = 1'b0;
    step(1);
    // load has priority over en, then wrap toggles mirror
    load = 1'b1; load_val = 6'd10;
    step(1);
    chk("l10_par", 8'(par_out), 8'd10);
    en = 1'b1; load_val = 6'd60;
    step(1);
    load = 1'b0;
    chk("l60_par", 8'(par_out), 8'd60);
    chk("l60_mirror", 8'(mirror), 8'd0);
    step(3);
    chk("l63_par", 8'(par_out), 8'd63);
    chk("l63_mirror", 8'(mirror), 8'd0);
    step(1);
    chk("l0_par", 8'(par_out), 8'd0);
    chk("l0_mirror", 8'(mirror), 8'd1);
`ifdef COUNTER_6BIT_SIGN_EN
    en = 1'b0; rst = 1'b1; #1;
    rst = 1'b0;
    chk("sign_rst", 8'(sign), 8'd0);
    en = 1'b1;
    step(127);
    chk("sign_127", 8'(sign), 8'd0);
    step(1);
    chk("sign_128", 8'(sign), 8'd1);
    step(127);
    chk("sign_255", 8'(sign), 8'd1);
    step(1);
    chk("sign_256", 8'(sign), 8'd0);
`endif
    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
